two_to_one_encoder: RTL and testbench
=====================================

TWO_TO_ONE_ENCODER -- requirements
Module: two_to_one_encoder

Interface
REQ-001 Parameter: ERR_W, default 4, width of the saturating error counter (legal range 1..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: Enable  input  1  qualifies line_0/line_1; when 0, inputs are ignored.
REQ-005 Port: line_0  input  1  one-hot select line 0 (decoder output 0 side).
REQ-006 Port: line_1  input  1  one-hot select line 1 (decoder output 1 side).
REQ-007 Port: out_valid  output  1  registered; code holds a captured encoding.
REQ-008 Port: out_ready  input  1  consumer accepts code when out_valid and out_ready are both 1 at a rising edge.
REQ-009 Port: code  output  1  registered encoding: 0 for line_0, 1 for line_1.
REQ-010 Port: invalid  output  1  registered one-cycle pulse flagging a non-one-hot input.
REQ-011 Port: err_count  output  ERR_W  registered saturating count of invalid events.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE (out_valid=0) and HOLD (out_valid=1); out_valid SHALL be decoded from state only.
REQ-013 A "valid input" SHALL mean Enable=1 with exactly one of line_0/line_1 high; an "invalid input" SHALL mean Enable=1 with both high.
REQ-014 In IDLE, a valid input at a rising edge SHALL load code (line_1 value) and move to HOLD; latency input->out_valid is exactly 1 cycle.
REQ-015 In IDLE, Enable=0 or both lines low SHALL leave state, code and out_valid unchanged.
REQ-016 In HOLD with out_ready=0, code and out_valid SHALL remain stable regardless of inputs.
REQ-017 In HOLD with out_ready=1 and a valid input in the same cycle, the block SHALL load the new code and remain in HOLD (back-to-back, one transfer per cycle).
REQ-018 In HOLD with out_ready=1 and no valid input, the block SHALL return to IDLE; out_valid low the next cycle; code retains its last value.
REQ-019 An invalid input in any state SHALL assert invalid for exactly the next cycle and SHALL NOT change state or code.
REQ-020 Sustained invalid inputs SHALL pulse invalid on every cycle they are present (invalid high continuously while condition persists, delayed one cycle).
REQ-021 Each invalid input SHALL increment err_count by 1, saturating at 2^ERR_W-1 with no wrap.
REQ-022 invalid and err_count SHALL be unaffected by out_ready and by the FSM state.
REQ-023 code SHALL only change on a capture (REQ-014/REQ-017); never on invalid or idle cycles.

Reset
REQ-024 rst=1 SHALL immediately (without clock) force state=IDLE, out_valid=0, code=0, invalid=0, err_count=0.
REQ-025 rst asserted mid-HOLD SHALL discard the pending code with no handshake; the consumer sees out_valid fall asynchronously.
REQ-026 After rst deasserts, the first capture SHALL occur at the first rising edge with a valid input.

Verification
REQ-027 Reset then Enable=1, line_0=0, line_1=1, out_ready=0 for 1 cycle -> next cycle out_valid=1, code=1; held for 5 cycles with out_ready=0.
REQ-028 HOLD with code=1, drive out_ready=1 and line_0=1, line_1=0 same cycle -> next cycle out_valid=1, code=0 (back-to-back); then out_ready=1 with lines low -> out_valid=0, code=0 retained.
REQ-029 Enable=0, line_0=1, line_1=0 for 4 cycles -> out_valid stays 0, invalid stays 0, err_count=0.
REQ-030 Enable=1, line_0=line_1=1 for 3 cycles in IDLE -> invalid high 3 cycles (one-cycle delay), err_count=3, out_valid=0, code unchanged.
REQ-031 ERR_W=2, 6 invalid cycles -> err_count sequence 1,2,3,3,3,3 (saturate at 3).
REQ-032 In HOLD with code=1, assert rst between clock edges -> out_valid=0, code=0, err_count=0 before the next edge; after release, valid line_0 input -> out_valid=1, code=0 one cycle later.

Source files
------------

// File: rtl/two_to_one_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : two_to_one_encoder_if
// Description : Bundle for the 2:1 one-hot encoder. Carries the qualified
//               one-hot select lines, the valid/ready output handshake with
//               the encoded bit, and the error reporting signals.
//               master : drives Enable/line_0/line_1/out_ready, observes the rest
//               slave  : the encoder itself
// Revision    : 1.0  initial release
// ============================================================================
interface two_to_one_encoder_if #(
    parameter int ERR_W = 4
);
    logic             Enable;
    logic             line_0;
    logic             line_1;
    logic             out_ready;
    logic             out_valid;
    logic             code;
    logic             invalid;
    logic [ERR_W-1:0] err_count;

    modport master (
        output Enable, line_0, line_1, out_ready,
        input  out_valid, code, invalid, err_count
    );

    modport slave (
        input  Enable, line_0, line_1, out_ready,
        output out_valid, code, invalid, err_count
    );
endinterface
`default_nettype wire

// File: rtl/two_to_one_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : two_to_one_encoder
// Description : Encodes a qualified one-hot pair (line_0/line_1) into a single
//               code bit presented through a valid/ready handshake. Non-one-hot
//               (both high) inputs raise a one-cycle invalid pulse and bump a
//               saturating error counter.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - two_to_one_encoder_if.slave
//                      in : Enable, line_0, line_1, out_ready
//                      out: out_valid, code, invalid, err_count[ERR_W-1:0]
// Revision    : 1.0  initial release
// ============================================================================
module two_to_one_encoder #(
    parameter int ERR_W = 4
) (
    input  wire                        clk,
    input  wire                        rst,
    two_to_one_encoder_if.slave        bus
);

    localparam logic [0:0]       c_S_IDLE  = 1'b0;
    localparam logic [0:0]       c_S_HOLD  = 1'b1;
    localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_code;
    logic             r_invalid;
    logic [ERR_W-1:0] r_err_count;

    logic             w_valid_in;
    logic             w_invalid_in;
    logic             w_capture;

    assign w_valid_in   = bus.Enable & (bus.line_0 ^ bus.line_1);
    assign w_invalid_in = bus.Enable & bus.line_0 & bus.line_1;

    // A capture happens from IDLE, or from HOLD when the consumer takes the
    // current code in the same cycle (back-to-back transfer).
    assign w_capture = w_valid_in & ((r_state == c_S_IDLE) | bus.out_ready);

    // Handshake FSM and code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_code  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_code  <= bus.line_1;
                r_state <= c_S_HOLD;
            end else if ((r_state == c_S_HOLD) && bus.out_ready && !w_invalid_in) begin
                // An invalid input freezes the FSM even while out_ready is
                // high, so the held code stays presented in that cycle.
                r_state <= c_S_IDLE;
            end
        end
    end

    // Error reporting is independent of the handshake state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_invalid   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_invalid <= w_invalid_in;
            if (w_invalid_in && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + c_ERR_ONE;
            end
        end
    end

    assign bus.out_valid = (r_state == c_S_HOLD);
    assign bus.code      = r_code;
    assign bus.invalid   = r_invalid;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_two_to_one_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_two_to_one_encoder
// Description : Self-checking bench for two_to_one_encoder. Two instances
//               (ERR_W=4 and ERR_W=2) share the same stimulus. Directed vector
//               table, hand-written reset/saturation sequences, then random
//               stimulus against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_two_to_one_encoder;

    logic clk;
    logic rst;
    logic en, l0, l1, rdy;

    two_to_one_encoder_if #(.ERR_W(4)) u_if4 ();
    two_to_one_encoder_if #(.ERR_W(2)) u_if2 ();

    assign u_if4.Enable    = en;
    assign u_if4.line_0    = l0;
    assign u_if4.line_1    = l1;
    assign u_if4.out_ready = rdy;
    assign u_if2.Enable    = en;
    assign u_if2.line_0    = l0;
    assign u_if2.line_1    = l1;
    assign u_if2.out_ready = rdy;

    two_to_one_encoder #(.ERR_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));
    two_to_one_encoder #(.ERR_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the observable outputs as plain values
    bit m_valid, m_code, m_inv;
    int m_cnt4, m_cnt2;

    typedef struct {
        bit en, l0, l1, rdy;
        bit exp_valid, exp_code, exp_inv;
        int exp_cnt4, exp_cnt2;
    } vec_t;

    vec_t tbl[$];

    task automatic model_reset();
        m_valid = 0; m_code = 0; m_inv = 0; m_cnt4 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input bit e, input bit a, input bit b, input bit r);
        bit vin, iin;
        vin = e && ((int'(a) + int'(b)) == 1);
        iin = e && a && b;
        m_inv = iin;
        if (iin) begin
            m_cnt4 = (m_cnt4 + 1 > 15) ? 15 : m_cnt4 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3)  ? 3  : m_cnt2 + 1;
        end
        if (vin && (!m_valid || r)) begin
            m_valid = 1;
            m_code  = b;
        end else if (m_valid && r && !iin) begin
            m_valid = 0;
        end
    endtask

    task automatic cmp(input string tag, input string field, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, field, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit ev, input bit ec, input bit ei,
                             input int e4, input int e2);
        cmp(tag, "out_valid", int'(u_if4.out_valid), int'(ev));
        cmp(tag, "code",      int'(u_if4.code),      int'(ec));
        cmp(tag, "invalid",   int'(u_if4.invalid),   int'(ei));
        cmp(tag, "err_count", int'(u_if4.err_count), e4);
        cmp(tag, "out_valid(w2)", int'(u_if2.out_valid), int'(ev));
        cmp(tag, "code(w2)",      int'(u_if2.code),      int'(ec));
        cmp(tag, "invalid(w2)",   int'(u_if2.invalid),   int'(ei));
        cmp(tag, "err_count(w2)", int'(u_if2.err_count), e2);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_valid, m_code, m_inv, m_cnt4, m_cnt2);
    endtask

    // Drive one cycle of inputs, let one rising edge consume them
    task automatic apply(input bit e, input bit a, input bit b, input bit r);
        en = e; l0 = a; l1 = b; rdy = r;
        @(posedge clk);
        model_step(e, a, b, r);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic push(input bit e, input bit a, input bit b, input bit r,
                        input bit ev, input bit ec, input bit ei, input int e4, input int e2);
        tbl.push_back('{e, a, b, r, ev, ec, ei, e4, e2});
    endtask

    initial begin
        rst = 1'b1; en = 0; l0 = 0; l1 = 0; rdy = 0;
        model_reset();

        // Load a capture, hold it, then back-to-back and drain
        push(1,0,1,0, 1,1,0, 0,0);
        push(0,0,0,0, 1,1,0, 0,0);
        push(1,1,0,0, 1,1,0, 0,0);
        push(1,0,1,0, 1,1,0, 0,0);
        push(0,1,0,0, 1,1,0, 0,0);
        push(0,0,0,0, 1,1,0, 0,0);
        push(1,1,0,1, 1,0,0, 0,0);
        push(1,0,0,1, 0,0,0, 0,0);
        // Disabled inputs ignored
        push(0,1,0,0, 0,0,0, 0,0);
        push(0,1,0,1, 0,0,0, 0,0);
        push(0,1,0,0, 0,0,0, 0,0);
        push(0,1,1,0, 0,0,0, 0,0);
        // Sustained invalid in IDLE
        push(1,1,1,0, 0,0,1, 1,1);
        push(1,1,1,0, 0,0,1, 2,2);
        push(1,1,1,0, 0,0,1, 3,3);
        push(0,0,0,0, 0,0,0, 3,3);
        // Invalid in HOLD with out_ready high: state and code frozen
        push(1,0,1,0, 1,1,0, 3,3);
        push(1,1,1,1, 1,1,1, 4,3);
        push(0,0,0,1, 0,1,0, 4,3);

        // Reset state, reset held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].l0, tbl[i].l1, tbl[i].rdy);
            check_all($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_code,
                      tbl[i].exp_inv, tbl[i].exp_cnt4, tbl[i].exp_cnt2);
        end

        // Saturation: six invalid cycles, narrow counter stops at 3
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            apply(1, 1, 1, k[0]);
            check_all($sformatf("sat%0d", k), 0, 0, 1, k, (k > 3) ? 3 : k);
        end

        // Asynchronous reset between edges while holding code=1
        apply(1, 0, 1, 0);
        check_all("hold_pre_rst", 1, 1, 0, 6, 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(1, 1, 0, 0);
        check_all("post_rst_capture", 1, 0, 0, 0, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
            check_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
